// File: rtl/fma16_pkg.sv
// Shared types for the fma16 datapath and its issue controller.
//   fma_op_t    : opcode-level FP16 operations (111 is reserved/illegal)
//   roundmode_t : rounding mode encoding understood by fma16
//   fma_ctrl_t  : fma16 control bundle {mul, add, negr, negz}
//   decode_op   : opcode -> fma16 controls
package fma16_pkg;

   localparam int unsigned FP16_W    = 16;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;

   typedef enum logic [2:0] {
      OP_FADD    = 3'b000,
      OP_FSUB    = 3'b001,
      OP_FMUL    = 3'b010,
      OP_FMADD   = 3'b011,
      OP_FMSUB   = 3'b100,
      OP_FNMADD  = 3'b101,
      OP_FNMSUB  = 3'b110,
      OP_ILLEGAL = 3'b111
   } fma_op_t;

   typedef enum logic [1:0] {
      RM_RZ  = 2'b00,
      RM_RNE = 2'b01,
      RM_RP  = 2'b10,
      RM_RN  = 2'b11
   } roundmode_t;

   typedef struct packed {
      logic mul;
      logic add;
      logic negr;
      logic negz;
   } fma_ctrl_t;

   // fma16 computes +/-(x*y +/- z); fadd/fsub are x + (+/-)z with mul off.
   function automatic fma_ctrl_t decode_op(fma_op_t op);
      fma_ctrl_t c;
      c = '0;
      case (op)
         OP_FADD:   c = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b0};
         OP_FSUB:   c = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b1};
         OP_FMUL:   c = '{mul: 1'b1, add: 1'b0, negr: 1'b0, negz: 1'b0};
         OP_FMADD:  c = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b0};
         OP_FMSUB:  c = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b1};
         OP_FNMADD: c = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b0};
         OP_FNMSUB: c = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b1};
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fma16_issue_ctrl.sv
// Initiator-side controller for the combinational fma16 datapath.
// Accepts one opcode-level request (valid/ready), drives fma16 operands and
// controls from registers for LATENCY cycles, captures fma_result and returns
// it on a valid/ready response channel. One operation in flight at a time.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   req_valid/req_ready/req_op/req_x/y/z/req_rm   request channel
//   fma_x/y/z, fma_mul/add/negr/negz, fma_roundmode  to fma16
//   fma_result                           from fma16
//   rsp_valid/rsp_ready/rsp_result/rsp_op/rsp_err response channel
//   ops_done                             completed-response counter (wraps)
module fma16_issue_ctrl
   import fma16_pkg::*;
#(
   parameter int unsigned LATENCY = 1,          // 1..15
   parameter logic [15:0] NAN_VAL = FP16_QNAN
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_x,
   input  logic [15:0] req_y,
   input  logic [15:0] req_z,
   input  logic [1:0]  req_rm,
   output logic [15:0] fma_x,
   output logic [15:0] fma_y,
   output logic [15:0] fma_z,
   output logic        fma_mul,
   output logic        fma_add,
   output logic        fma_negr,
   output logic        fma_negz,
   output logic [1:0]  fma_roundmode,
   input  logic [15:0] fma_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_err,
   output logic [15:0] ops_done
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DONE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FP16_W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
   fma_ctrl_t             ctrl_q, ctrl_d;
   roundmode_t            rm_q, rm_d;
   logic [FP16_W-1:0]     res_q, res_d;
   fma_op_t               op_q, op_d;
   logic                  err_q, err_d;
   logic [DONE_W-1:0]     ops_done_q, ops_done_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;

   fma_op_t               req_op_e;
   logic                  req_hs;
   logic                  rsp_hs;

   assign req_op_e = fma_op_t'(req_op);
   assign req_hs   = req_valid & req_ready_q;
   assign rsp_hs   = rsp_valid_q & rsp_ready;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         ctrl_q      <= '0;
         rm_q        <= RM_RZ;
         res_q       <= '0;
         op_q        <= OP_FADD;
         err_q       <= 1'b0;
         ops_done_q  <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         ctrl_q      <= ctrl_d;
         rm_q        <= rm_d;
         res_q       <= res_d;
         op_q        <= op_d;
         err_q       <= err_d;
         ops_done_q  <= ops_done_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      ctrl_d     = ctrl_q;
      rm_d       = rm_q;
      res_d      = res_q;
      op_d       = op_q;
      err_d      = err_q;
      ops_done_d = ops_done_q;

      case (state_q)
         IDLE: begin
            if (req_hs) begin
               op_d = req_op_e;
               if (req_op_e == OP_ILLEGAL) begin
                  // Datapath untouched: fma16 keeps its previous operands.
                  err_d   = 1'b1;
                  res_d   = NAN_VAL;
                  state_d = RESP;
               end else begin
                  x_d     = req_x;
                  y_d     = req_y;
                  z_d     = req_z;
                  rm_d    = roundmode_t'(req_rm);
                  ctrl_d  = decode_op(req_op_e);
                  cnt_d   = CNT_W'(LATENCY - 1);
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            // Counter hits 0 in the LATENCY-th EXEC cycle: sample the datapath.
            if (cnt_q == '0) begin
               res_d   = fma_result;
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_hs) begin
               ops_done_d = ops_done_q + DONE_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_result    = res_q;
   assign rsp_op        = op_q;
   assign rsp_err       = err_q;
   assign ops_done      = ops_done_q;
   assign fma_x         = x_q;
   assign fma_y         = y_q;
   assign fma_z         = z_q;
   assign fma_mul       = ctrl_q.mul;
   assign fma_add       = ctrl_q.add;
   assign fma_negr      = ctrl_q.negr;
   assign fma_negz      = ctrl_q.negz;
   assign fma_roundmode = rm_q;

endmodule

// File: tb/tb_fma16_issue_ctrl.sv
// Directed bench for fma16_issue_ctrl: one instance at LATENCY=1 with a
// constant result stub, one at LATENCY=3 with a combinational stub whose
// output depends on operands and controls.
module tb_fma16_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  req_op;
   logic [15:0] req_x, req_y, req_z;
   logic [1:0]  req_rm;

   // LATENCY=1 instance
   logic        req_valid1, req_ready1, rsp_ready1, rsp_valid1, rsp_err1;
   logic [15:0] fma_x1, fma_y1, fma_z1, fma_result1, rsp_result1, ops_done1;
   logic        fma_mul1, fma_add1, fma_negr1, fma_negz1;
   logic [1:0]  fma_rm1;
   logic [2:0]  rsp_op1;

   // LATENCY=3 instance
   logic        req_valid3, req_ready3, rsp_ready3, rsp_valid3, rsp_err3;
   logic [15:0] fma_x3, fma_y3, fma_z3, fma_result3, rsp_result3, ops_done3;
   logic        fma_mul3, fma_add3, fma_negr3, fma_negz3;
   logic [1:0]  fma_rm3;
   logic [2:0]  rsp_op3;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_done3;

   always #5 clk = ~clk;

   assign fma_result1 = 16'h4200;
   assign fma_result3 = fma_x3 ^ {fma_y3[7:0], fma_y3[15:8]} ^ fma_z3 ^
                        {12'h000, fma_mul3, fma_add3, fma_negr3, fma_negz3};

   fma16_issue_ctrl #(.LATENCY(1), .NAN_VAL(16'h7E00)) u_l1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
      .fma_x(fma_x1), .fma_y(fma_y1), .fma_z(fma_z1),
      .fma_mul(fma_mul1), .fma_add(fma_add1), .fma_negr(fma_negr1), .fma_negz(fma_negz1),
      .fma_roundmode(fma_rm1), .fma_result(fma_result1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1),
      .rsp_op(rsp_op1), .rsp_err(rsp_err1), .ops_done(ops_done1)
   );

   fma16_issue_ctrl #(.LATENCY(3), .NAN_VAL(16'h7E00)) u_l3 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
      .fma_x(fma_x3), .fma_y(fma_y3), .fma_z(fma_z3),
      .fma_mul(fma_mul3), .fma_add(fma_add3), .fma_negr(fma_negr3), .fma_negz(fma_negz3),
      .fma_roundmode(fma_rm3), .fma_result(fma_result3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
      .rsp_op(rsp_op3), .rsp_err(rsp_err3), .ops_done(ops_done3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected {mul, add, negr, negz} from the opcode table.
   function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
      case (op)
         3'b000:  return 4'b0100;
         3'b001:  return 4'b0101;
         3'b010:  return 4'b1000;
         3'b011:  return 4'b1100;
         3'b100:  return 4'b1101;
         3'b101:  return 4'b1110;
         3'b110:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [15:0] stub_res(input logic [15:0] x, y, z, input logic [2:0] op);
      return x ^ {y[7:0], y[15:8]} ^ z ^ {12'h000, exp_ctrl(op)};
   endfunction

   function automatic logic [15:0] ctl3();
      return {12'h000, fma_mul3, fma_add3, fma_negr3, fma_negz3};
   endfunction

   // Full legal operation on the LATENCY=3 instance, responded immediately.
   task automatic run3(input logic [2:0] op, input logic [15:0] x, y, z, input logic [1:0] rm);
      chk("pre_req_ready", 16'(req_ready3), 16'h1);
      req_op = op; req_x = x; req_y = y; req_z = z; req_rm = rm;
      req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      req_x = ~x; req_y = ~y; req_z = ~z;
      chk("ctrl", ctl3(), {12'h000, exp_ctrl(op)});
      chk("roundmode", 16'(fma_rm3), 16'(rm));
      chk("req_ready_exec", 16'(req_ready3), 16'h0);
      for (int i = 0; i < 3; i++) begin
         chk("exec_valid", 16'(rsp_valid3), 16'h0);
         chk("exec_x", fma_x3, x);
         chk("exec_y", fma_y3, y);
         chk("exec_z", fma_z3, z);
         tick();
      end
      chk("rsp_valid", 16'(rsp_valid3), 16'h1);
      chk("rsp_result", rsp_result3, stub_res(x, y, z, op));
      chk("rsp_op", 16'(rsp_op3), 16'(op));
      chk("rsp_err", 16'(rsp_err3), 16'h0);
      rsp_ready3 = 1'b1;
      tick();
      rsp_ready3 = 1'b0;
      exp_done3 = exp_done3 + 16'h1;
      chk("post_valid", 16'(rsp_valid3), 16'h0);
      chk("post_ready", 16'(req_ready3), 16'h1);
      chk("ops_done", ops_done3, exp_done3);
   endtask

   initial begin
      logic [15:0] held;
      reset_n    = 1'b0;
      req_valid1 = 1'b0; rsp_ready1 = 1'b0;
      req_valid3 = 1'b0; rsp_ready3 = 1'b0;
      req_op = 3'b000; req_x = '0; req_y = '0; req_z = '0; req_rm = 2'b00;
      exp_done3 = '0;

      // Reset values
      tick();
      chk("rst_req_ready", 16'(req_ready3), 16'h0);
      chk("rst_rsp_valid", 16'(rsp_valid3), 16'h0);
      chk("rst_ops_done", ops_done3, 16'h0);
      chk("rst_fma_x", fma_x3, 16'h0);
      reset_n = 1'b1;
      tick();
      chk("rel_req_ready", 16'(req_ready3), 16'h1);

      // Reset while in EXEC discards the operation
      req_op = 3'b011; req_x = 16'h3C00; req_y = 16'h4000; req_z = 16'h3C00; req_rm = 2'b01;
      req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      chk("midexec_mul", 16'(fma_mul3), 16'h1);
      reset_n = 1'b0;
      #1;
      chk("midrst_mul", 16'(fma_mul3), 16'h0);
      chk("midrst_rsp_valid", 16'(rsp_valid3), 16'h0);
      chk("midrst_ops_done", ops_done3, 16'h0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("midrel_req_ready", 16'(req_ready3), 16'h1);
      chk("midrel_mul", 16'(fma_mul3), 16'h0);
      for (int i = 0; i < 5; i++) begin
         chk("midrel_no_rsp", 16'(rsp_valid3), 16'h0);
         tick();
      end

      // fmadd on LATENCY=1 with constant stub result
      req_op = 3'b011; req_x = 16'h3C00; req_y = 16'h4000; req_z = 16'h3C00; req_rm = 2'b01;
      req_valid1 = 1'b1;
      tick();
      req_valid1 = 1'b0;
      chk("l1_ctrl", {12'h000, fma_mul1, fma_add1, fma_negr1, fma_negz1}, 16'h000C);
      chk("l1_x", fma_x1, 16'h3C00);
      chk("l1_valid_early", 16'(rsp_valid1), 16'h0);
      tick();
      chk("l1_valid", 16'(rsp_valid1), 16'h1);
      chk("l1_result", rsp_result1, 16'h4200);
      chk("l1_op", 16'(rsp_op1), 16'h3);
      rsp_ready1 = 1'b1;
      tick();
      rsp_ready1 = 1'b0;
      chk("l1_ops_done", ops_done1, 16'h1);
      chk("l1_valid_drop", 16'(rsp_valid1), 16'h0);

      // All legal opcodes on LATENCY=3
      run3(3'b000, 16'h3C00, 16'h0000, 16'h4000, 2'b00);
      run3(3'b001, 16'h4400, 16'h1234, 16'h3C00, 2'b01);
      run3(3'b010, 16'h4000, 16'h4200, 16'h0000, 2'b10);
      run3(3'b011, 16'h3C00, 16'h4000, 16'h3C00, 2'b11);
      run3(3'b100, 16'hC000, 16'h3800, 16'h7BFF, 2'b01);
      run3(3'b101, 16'h0001, 16'h8001, 16'hFC00, 2'b00);
      run3(3'b110, 16'h5555, 16'hAAAA, 16'h0F0F, 2'b10);

      // Illegal opcode: immediate NaN response, datapath untouched
      req_op = 3'b111; req_x = 16'h1111; req_y = 16'h2222; req_z = 16'h3333; req_rm = 2'b11;
      req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      chk("ill_valid", 16'(rsp_valid3), 16'h1);
      chk("ill_err", 16'(rsp_err3), 16'h1);
      chk("ill_result", rsp_result3, 16'h7E00);
      chk("ill_op", 16'(rsp_op3), 16'h7);
      chk("ill_fma_x", fma_x3, 16'h5555);
      chk("ill_fma_z", fma_z3, 16'h0F0F);
      chk("ill_ctrl", ctl3(), 16'h000F);
      chk("ill_rm", 16'(fma_rm3), 16'h2);
      rsp_ready3 = 1'b1;
      tick();
      rsp_ready3 = 1'b0;
      exp_done3 = exp_done3 + 16'h1;
      chk("ill_ops_done", ops_done3, exp_done3);

      // Back-pressure with a pending new request
      req_op = 3'b010; req_x = 16'h4000; req_y = 16'h4400; req_z = 16'h0000; req_rm = 2'b01;
      req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      tick(); tick(); tick();
      held = stub_res(16'h4000, 16'h4400, 16'h0000, 3'b010);
      chk("bp_valid", 16'(rsp_valid3), 16'h1);
      chk("bp_result0", rsp_result3, held);
      req_op = 3'b001; req_x = 16'h4800; req_y = 16'h0101; req_z = 16'h3C00; req_rm = 2'b10;
      req_valid3 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_req_ready", 16'(req_ready3), 16'h0);
         chk("bp_hold_valid", 16'(rsp_valid3), 16'h1);
         chk("bp_hold_result", rsp_result3, held);
         chk("bp_hold_x", fma_x3, 16'h4000);
         tick();
      end
      rsp_ready3 = 1'b1;
      tick();
      rsp_ready3 = 1'b0;
      exp_done3 = exp_done3 + 16'h1;
      chk("bp_drop_valid", 16'(rsp_valid3), 16'h0);
      chk("bp_idle_ready", 16'(req_ready3), 16'h1);
      chk("bp_idle_x", fma_x3, 16'h4000);
      chk("bp_ops_done", ops_done3, exp_done3);
      tick();
      req_valid3 = 1'b0;
      chk("bp_accept_x", fma_x3, 16'h4800);
      chk("bp_accept_ctrl", ctl3(), 16'h0005);
      tick(); tick(); tick();
      chk("bp_new_valid", 16'(rsp_valid3), 16'h1);
      chk("bp_new_result", rsp_result3, stub_res(16'h4800, 16'h0101, 16'h3C00, 3'b001));
      rsp_ready3 = 1'b1;
      tick();
      rsp_ready3 = 1'b0;
      exp_done3 = exp_done3 + 16'h1;
      chk("bp_new_done", ops_done3, exp_done3);

      // Counter wrap FFFF -> 0000
      force u_l3.ops_done_q = 16'hFFFF;
      #1;
      release u_l3.ops_done_q;
      #1;
      chk("wrap_pre", ops_done3, 16'hFFFF);
      exp_done3 = 16'hFFFF;
      run3(3'b001, 16'h3C00, 16'h0000, 16'h3C00, 2'b01);
      chk("wrap_zero", ops_done3, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
